// File: rtl/pc_sequencer.sv
// pc_sequencer: Mealy controller driving PCSrc/immediate of an external PC with branch, call/return stack, stall, flush and halt
module pc_sequencer #(
  parameter int AW           = 8,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] pc_in,
  input  logic          mem_ready,
  input  logic          br_taken,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic [AW-1:0] br_target,
  output logic          PCSrc,
  output logic [AW-1:0] immediate,
  output logic          flush,
  output logic          halted,
  output logic          stk_ovf,
  output logic          stk_unf
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0] stk_q [DEPTH];
  logic          push, load, empty, full;
  logic [AW-1:0] imm, top;
  assign empty = sp_q == '0;
  assign full  = sp_q == SW'(DEPTH);
  assign top   = stk_q[sp_q[IW-1:0] - IW'(1)];
  // next-state and PC-select decision; load=1 means hold/redirect to imm, load=0 means increment
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    load    = 1'b1;
    imm     = pc_in;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        load    = !mem_ready;
      end
      RUN: if (mem_ready) begin
        if (halt) state_d = HALT;
        else if (ret && !empty) begin
          sp_d    = sp_q - SW'(1);
          imm     = top;
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES);
        end else if (ret) begin
          unf_d = 1'b1;
          load  = 1'b0;
        end else if (call || br_taken) begin
          imm     = br_target;
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES);
          if (call && full) ovf_d = 1'b1;
          else if (call) begin
            push = 1'b1;
            sp_d = sp_q + SW'(1);
          end
        end else load = 1'b0;
      end
      FLUSH: if (mem_ready) begin
        load  = 1'b0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: ;
    endcase
  end
  // control state, stack pointer, flush counter and sticky flags
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // return-address storage; contents survive reset, only the pointer is cleared
  always_ff @(posedge CLK) begin
    if (push) stk_q[sp_q[IW-1:0]] <= pc_in + AW'(1);
  end
  assign PCSrc     = reset || load;
  assign immediate = (reset || !load) ? '0 : imm;
  assign flush     = state_q == FLUSH;
  assign halted    = state_q == HALT;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;
endmodule
